prbs9_checker: RTL
==================

# prbs9_checker

PRBS9 receive-side checker (x^9 + x^5 + 1) consuming the bit stream produced by the PRBS9 generator after the channel. It self-synchronises to the incoming stream and tracks lock. It counts compared bits and bit errors for BER measurement. It sits at the end of the receive path, after bit slicing, and is read by the register/monitor logic.

## Interface
Parameters:
- LOCK_CNT, 32: consecutive correct predictions required to declare lock (≥1).
- WIN_LEN, 128: loss-of-lock observation window, in compared bits (only with resync feature).
- ERR_THR, 8: errors within one window that force loss of lock (1..WIN_LEN).
- CNT_W, 32: width of bit and error counters.

Ports:
- clk, input, 1: single clock, all state updates on posedge.
- i_reset, input, 1: synchronous, active-high reset.
- i_ctrl, input, 1: sample enable; i_rx_bit is consumed only in cycles where this is 1; otherwise all state holds.
- i_rx_bit, input, 1: received PRBS bit.
- i_clr_cnt, input, 1: synchronous clear of o_bit_count and o_err_count; does not affect lock.
- o_locked, output, 1: checker is locked.
- o_err, output, 1: one-cycle pulse per mismatching bit while locked.
- o_bit_count, output, CNT_W: bits compared while locked, saturating.
- o_err_count, output, CNT_W: mismatches while locked, saturating.

## Operation
- Prediction: 9-bit history hist, with hist[k] = sample k+1 enables ago. Predicted bit p = hist[8] ^ hist[4], which is the same recurrence as the generator: o[n] = o[n-9] ^ o[n-5].
- FSM states are FILL, SEARCH and LOCKED. Reset state is FILL.
- FILL:
  - Per enabled sample: hist <= {hist[7:0], i_rx_bit}, and the fill counter increments.
  - After the 9th sample, go to SEARCH.
- SEARCH:
  - Per enabled sample: hist loads i_rx_bit (open loop).
  - If i_rx_bit == p and hist != 0, the match counter increments. Otherwise the match counter clears.
  - The all-zero stream never locks.
  - When a match makes the count reach LOCK_CNT, go to LOCKED and clear the match counter.
- LOCKED:
  - Per enabled sample: hist <= {hist[7:0], p}. The local LFSR is free-running, so received errors do not propagate.
  - o_bit_count increments.
  - If i_rx_bit != p: o_err pulses and o_err_count increments.
- Counters:
  - Both saturate at 2^CNT_W − 1 and hold.
  - i_clr_cnt wins over a same-cycle increment; the result is 0.
  - Counters do not change outside LOCKED.
- Reset:
  - Values: hist=0, fill and match counters = 0, state FILL, o_locked=0, o_err=0, both counts 0.
  - Reset mid-operation, including while LOCKED, fully restarts acquisition.
- i_ctrl=0 in any state: no shift, no count, o_err=0.

## Timing
- All outputs are registered.
- o_err and count updates are visible in the cycle after the enabled sample that caused them.
- Acquisition from reset with a clean stream and i_ctrl=1 continuously:
  - samples 1–9 fill the history;
  - samples 10..9+LOCK_CNT match;
  - o_locked rises the cycle after sample 9+LOCK_CNT, which is sample 41 at default.
- The first compared bit in LOCKED is the next enabled sample after lock.
- o_locked falls (resync feature only) the cycle after the sample that reaches ERR_THR. From that point the FSM is in SEARCH, and hist continues loading received bits.

## Configuration
- Macro PRBS9_CHK_RESYNC_EN.
- Defined:
  - While LOCKED, a window counter counts compared bits modulo WIN_LEN, and a window error counter counts mismatches.
  - When the window error count reaches ERR_THR, go to SEARCH immediately. That sample is still counted in o_err_count.
  - When the window completes without reaching ERR_THR, both window counters clear.
  - Both window counters clear on every entry to LOCKED.
- Not defined:
  - LOCKED is absorbing until i_reset.
  - WIN_LEN and ERR_THR are unused.

## Structure
- Shared package prbs9_pkg:
  - PRBS9_LEN = 9, tap indices 8 and 4;
  - FSM state enum (FILL, SEARCH, LOCKED);
  - the all-zero constant.
  - The generator uses the same tap constants.
- One sub-module: prbs9_err_window, holding the window and window-error counters plus the threshold compare. It is instantiated only under PRBS9_CHK_RESYNC_EN.

## Test plan
- Clean generator stream (SEED 9'h1FF), i_ctrl=1 -> o_locked rises the cycle after sample 41; after 1000 further bits o_bit_count=1000, o_err_count=0.
- Locked, invert 3 isolated bits spaced ≥10 apart -> exactly 3 o_err pulses and o_err_count=3, with no error multiplication; o_locked stays 1.
- All-zero input for 200 cycles -> o_locked stays 0 and counters stay 0.
- i_ctrl toggled 1/0 every cycle on a clean stream -> lock at the 41st enabled sample; counters advance only on enabled cycles.
- With PRBS9_CHK_RESYNC_EN: locked, then random data, ERR_THR=8 -> o_locked falls after the 8th error in the window; restoring the clean stream relocks after 32 matches. Without the macro -> o_locked stays 1.
- Counters: CNT_W=4 saturates at 15; i_clr_cnt asserted with a mismatch in the same cycle -> both counts read 0 on the next cycle. i_reset while locked -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/prbs9_pkg.sv
// ============================================================================
// Module  : prbs9_pkg
// Brief   : Shared PRBS9 (x^9 + x^5 + 1) constants, FSM state type and predictor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package prbs9_pkg;

    localparam int PRBS9_LEN   = 9;
    localparam int PRBS9_TAP_A = 8;
    localparam int PRBS9_TAP_B = 4;

    localparam logic [PRBS9_LEN-1:0] PRBS9_ZERO = '0;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } prbs9_state_t;

    // hist[k] holds the bit seen k+1 samples ago, so this is o[n-9] ^ o[n-5].
    function automatic logic prbs9_predict(input logic [PRBS9_LEN-1:0] hist);
        return hist[PRBS9_TAP_A] ^ hist[PRBS9_TAP_B];
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs9_err_window.sv
// ============================================================================
// Module  : prbs9_err_window
// Brief   : Loss-of-lock window: counts compared bits modulo WIN_LEN and the
//           mismatches inside the window; flags the sample that reaches ERR_THR.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs9_err_window #(
    parameter int WIN_LEN = 128,
    parameter int ERR_THR = 8
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_step,
    input  logic i_mismatch,
    output logic o_trip
);

    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int ERR_W = (ERR_THR > 1) ? $clog2(ERR_THR) : 1;

    localparam logic [WIN_W-1:0] C_WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [ERR_W-1:0] C_ERR_LAST = ERR_W'(ERR_THR - 1);

    logic [WIN_W-1:0] r_win_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    assign o_trip = i_step && i_mismatch && (r_err_cnt == C_ERR_LAST);

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
        end else if (i_step) begin
            if (o_trip || (r_win_cnt == C_WIN_LAST)) begin
                r_win_cnt <= '0;
                r_err_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                if (i_mismatch) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prbs9_checker.sv
// ============================================================================
// Module  : prbs9_checker
// Brief   : Self-synchronising PRBS9 receive checker with lock tracking and
//           saturating bit/error counters. Define PRBS9_CHK_RESYNC_EN to enable
//           window-based loss of lock (otherwise LOCKED holds until reset).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs9_checker
    import prbs9_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int WIN_LEN  = 128,
    parameter int ERR_THR  = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_ctrl,
    input  logic             i_rx_bit,
    input  logic             i_clr_cnt,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [MATCH_W-1:0] C_LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [3:0]         C_FILL_LAST = 4'(PRBS9_LEN - 1);
    localparam logic [CNT_W-1:0]   C_CNT_MAX   = '1;

    generate
        if (LOCK_CNT < 1 || ERR_THR < 1 || ERR_THR > WIN_LEN) begin : g_cfg_err
            $error("prbs9_checker: illegal LOCK_CNT/ERR_THR/WIN_LEN combination");
        end
    endgenerate

    prbs9_state_t         r_state;
    logic [PRBS9_LEN-1:0] r_hist;
    logic [3:0]           r_fill_cnt;
    logic [MATCH_W-1:0]   r_match_cnt;

    logic w_pred;
    logic w_mismatch;
    logic w_step_locked;
    logic w_trip;

    assign w_pred        = prbs9_predict(r_hist);
    assign w_mismatch    = i_rx_bit ^ w_pred;
    assign w_step_locked = i_ctrl && (r_state == ST_LOCKED);

`ifdef PRBS9_CHK_RESYNC_EN
    // Held in clear outside LOCKED, so every lock entry starts a fresh window.
    prbs9_err_window #(
        .WIN_LEN (WIN_LEN),
        .ERR_THR (ERR_THR)
    ) u_err_window (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_clear    (r_state != ST_LOCKED),
        .i_step     (w_step_locked),
        .i_mismatch (w_mismatch),
        .o_trip     (w_trip)
    );
`else
    assign w_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state     <= ST_FILL;
            r_hist      <= PRBS9_ZERO;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (i_ctrl) begin
                case (r_state)
                    ST_FILL: begin
                        r_hist <= {r_hist[PRBS9_LEN-2:0], i_rx_bit};
                        if (r_fill_cnt == C_FILL_LAST) begin
                            r_fill_cnt <= '0;
                            r_state    <= ST_SEARCH;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                    end
                    ST_SEARCH: begin
                        r_hist <= {r_hist[PRBS9_LEN-2:0], i_rx_bit};
                        if (!w_mismatch && (r_hist != PRBS9_ZERO)) begin
                            if (r_match_cnt == C_LOCK_LAST) begin
                                r_match_cnt <= '0;
                                r_state     <= ST_LOCKED;
                                o_locked    <= 1'b1;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-running local LFSR: received errors never enter hist.
                        r_hist <= {r_hist[PRBS9_LEN-2:0], w_pred};
                        o_err  <= w_mismatch;
                        if (w_trip) begin
                            r_state  <= ST_SEARCH;
                            o_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_FILL;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_clr_cnt) begin
            o_bit_count <= '0;
            o_err_count <= '0;
        end else if (w_step_locked) begin
            if (o_bit_count != C_CNT_MAX) begin
                o_bit_count <= o_bit_count + 1'b1;
            end
            if (w_mismatch && (o_err_count != C_CNT_MAX)) begin
                o_err_count <= o_err_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
